// File: rtl/instr_fetch_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_if -- instruction-memory fetch bus.
//
// Signals
//   imem_req     fetch -> memory   one-cycle request strobe
//   imem_addr    fetch -> memory   word-aligned fetch address, valid with imem_req
//   imem_rvalid  memory -> fetch   response strobe, at least one cycle after the request
//   imem_rdata   memory -> fetch   fetched instruction, valid with imem_rvalid
//
// Modports
//   master  instruction fetch unit (drives the request)
//   slave   instruction memory (drives the response)
// ----------------------------------------------------------------------------
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch -- instruction fetch unit with a small instruction buffer.
//
// Issues at most one instruction-memory request at a time, buffers returned
// instructions (with their PC) in a FIFO of FIFO_DEPTH entries and presents
// the buffer head to decode. A redirect flushes the buffer, discards any
// in-flight response and restarts fetching at the new address.
//
// Parameters
//   RESET_PC    PC loaded on reset
//   FIFO_DEPTH  instruction-buffer entries (2..8)
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   stall        decode cannot accept; buffer head is held
//   redirect     taken branch/jump: flush and refetch
//   redirect_pc  new fetch address (bits [1:0] ignored)
//   imem         instruction-memory bus (master side)
//   instr        buffer-head instruction, NOP (addi x0,x0,0) when empty
//   instr_pc     PC of instr, 0 when empty
//   instr_valid  buffer non-empty
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    instr_fetch_if.master        imem,
    output logic [31:0]          instr,
    output logic [31:0]          instr_pc,
    output logic                 instr_valid
);

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    // IDLE: nothing outstanding; WAIT: outstanding, keep; DROP: outstanding, discard.
    typedef enum logic [1:0] {IDLE, WAIT, DROP} req_state_e;

    req_state_e     state_q, state_d;
    logic [31:0]    pc_q;
    logic [31:0]    req_pc_q;
    logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]  count_q;

    logic [31:0]    buf_instr [FIFO_DEPTH];
    logic [31:0]    buf_pc    [FIFO_DEPTH];

    logic           push, pop, issue;
    logic [CW:0]    occ_end;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Reset overrides the buffer contents immediately, so the outputs read
    // as empty during a reset cycle even if entries are still stored.
    assign instr_valid = !rst && (count_q != '0);
    assign instr       = instr_valid ? buf_instr[rd_ptr_q] : NOP;
    assign instr_pc    = instr_valid ? buf_pc[rd_ptr_q]    : 32'h0;

    assign imem.imem_req  = issue;
    assign imem.imem_addr = pc_q;

    // NOTE: every signal assigned in this block gets a default at the top,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        pop     = instr_valid && !stall;
        push    = imem.imem_rvalid && (state_q == WAIT) && !redirect;
        occ_end = (CW+1)'(count_q) + (CW+1)'(push) - (CW+1)'(pop);
        // A new request needs the previous one retired by the end of this
        // cycle and a guaranteed free slot for its response.
        issue   = !rst && !redirect
                  && ((state_q == IDLE) || imem.imem_rvalid)
                  && (occ_end < (CW+1)'(FIFO_DEPTH));
        state_d = state_q;

        if (redirect) begin
            if (imem.imem_rvalid || (state_q == IDLE)) begin
                state_d = IDLE;
            end else begin
                state_d = DROP;
            end
        end else if (issue) begin
            state_d = WAIT;
        end else if (imem.imem_rvalid && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (redirect) begin
                pc_q     <= {redirect_pc[31:2], 2'b00};
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (issue) begin
                    pc_q     <= pc_q + 32'd4;
                    req_pc_q <= pc_q;
                end
                if (push) begin
                    wr_ptr_q <= ptr_inc(wr_ptr_q);
                end
                if (pop) begin
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end
                count_q <= occ_end[CW-1:0];
            end
        end
    end

    // NOTE: the buffer storage has no reset; count_q alone decides which
    // entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            buf_instr[wr_ptr_q] <= imem.imem_rdata;
            buf_pc[wr_ptr_q]    <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch -- directed cycle-by-cycle vectors for instr_fetch
// (default parameters: RESET_PC = 0, FIFO_DEPTH = 2), followed by two
// hand-written multi-cycle sequences (stall fill-up, redirect while full).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] instr, instr_pc;
    logic        instr_valid;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_if imem ();

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem.master),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst, stall, redir;
        logic [31:0] rpc;
        logic        rvalid;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr, ipc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic s, logic d, logic [31:0] rp,
                                logic rv, logic [31:0] rd, logic q,
                                logic [31:0] a, logic v, logic [31:0] i,
                                logic [31:0] p);
        vec_t t;
        t.rst = r; t.stall = s; t.redir = d; t.rpc = rp; t.rvalid = rv;
        t.rdata = rd; t.req = q; t.addr = a; t.valid = v; t.instr = i; t.ipc = p;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic d,
                         input logic [31:0] rp, input logic rv, input logic [31:0] rd);
        rst = r; stall = s; redirect = d; redirect_pc = rp;
        imem.imem_rvalid = rv; imem.imem_rdata = rd;
    endtask

    initial begin
        int          n_req;
        logic        pending;
        logic [31:0] pend_addr;
        logic [31:0] req_addrs [2];
        logic        found;

        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'h0;

        //        rst s  d  redirect_pc     rv rdata          req addr           v  instr          ipc
        // reset state
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, NOP,           32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, NOP,           32'h0));
        // streaming, latency 1: addresses 0,4,8,C; instr_pc one cycle after rvalid
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, NOP,           32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hAA00_0000, 1, 32'h4,       0, NOP,           32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hAA00_0004, 1, 32'h8,       1, 32'hAA00_0000, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hAA00_0008, 1, 32'hC,       1, 32'hAA00_0004, 32'h4));
        // reset while WAIT with one entry buffered: outputs forced empty
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, NOP,           32'h0));
        // late response after release is ignored; fetch restarts at RESET_PC
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'hDEAD_BEEF, 1, 32'h0,       0, NOP,           32'h0));
        // stall held: two entries (pc 0, 4) fill the buffer, then no requests
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'hAA00_0000, 1, 32'h4,       0, NOP,           32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'hAA00_0004, 0, 32'h0,       1, 32'hAA00_0000, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'hAA00_0000, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'hAA00_0000, 32'h0));
        // stall released: pops in order, fetch resumes at 8
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h8,        1, 32'hAA00_0000, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'hAA00_0004, 32'h4));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hAA00_0008, 1, 32'hC,       0, NOP,           32'h0));
        // redirect to 0x40 coincident with rvalid, one entry buffered
        vecs.push_back(mk(0, 0, 1, 32'h40,       1, 32'hAA00_000C, 0, 32'h0,       1, 32'hAA00_0008, 32'h8));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h40,       0, NOP,           32'h0));
        // redirect to 0x102 while WAIT: late response dropped, refetch 0x100
        vecs.push_back(mk(0, 0, 1, 32'h102,      0, 32'h0,        0, 32'h0,        0, NOP,           32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hAA00_0040, 1, 32'h100,     0, NOP,           32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, NOP,           32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hAA00_0100, 1, 32'h104,     0, NOP,           32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'hAA00_0100, 32'h100));
        // redirect to FFFF_FFFC while WAIT: DROP holds, then wrap to 0
        vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,       0, 32'h0,        0, NOP,           32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, NOP,           32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hAA00_0104, 1, 32'hFFFF_FFFC, 0, NOP,         32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hC0DE_FFFC, 1, 32'h0,       0, NOP,           32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hC0DE_0000, 1, 32'h4,       1, 32'hC0DE_FFFC, 32'hFFFF_FFFC));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'hC0DE_0000, 32'h0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].rpc,
                  vecs[i].rvalid, vecs[i].rdata);
            #1;
            check($sformatf("v%0d imem_req", i), 32'(imem.imem_req), 32'(vecs[i].req));
            if (vecs[i].req)
                check($sformatf("v%0d imem_addr", i), imem.imem_addr, vecs[i].addr);
            check($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].valid));
            check($sformatf("v%0d instr", i), instr, vecs[i].instr);
            check($sformatf("v%0d instr_pc", i), instr_pc, vecs[i].ipc);
        end

        // Sequence A: reset, then stall held with a latency-1 memory for
        // eight cycles; exactly two requests (0, 4) must be issued.
        @(negedge clk);
        drive(1, 0, 0, 32'h0, 0, 32'h0);
        n_req = 0;
        pending = 1'b0;
        pend_addr = 32'h0;
        req_addrs[0] = 32'hFFFF_FFFF;
        req_addrs[1] = 32'hFFFF_FFFF;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            drive(0, 1, 0, 32'h0, pending, 32'hAA00_0000 + pend_addr);
            #1;
            pending = 1'b0;
            if (imem.imem_req) begin
                if (n_req < 2) req_addrs[n_req] = imem.imem_addr;
                n_req++;
                pending = 1'b1;
                pend_addr = imem.imem_addr;
            end
        end
        check("stall_fill req count", 32'(n_req), 32'd2);
        check("stall_fill first addr", req_addrs[0], 32'h0);
        check("stall_fill second addr", req_addrs[1], 32'h4);
        check("stall_fill head pc", instr_pc, 32'h0);
        check("stall_fill head instr", instr, 32'hAA00_0000);

        // Sequence B: redirect with the buffer full and stall held; the
        // flush wins and the next fetch is 0x200 (low bits cleared).
        @(negedge clk);
        drive(0, 1, 1, 32'h0000_0203, 0, 32'h0);
        #1;
        check("redir_full req", 32'(imem.imem_req), 32'd0);
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(0, 1, 0, 32'h0, 0, 32'h0);
            #1;
            if (k == 0)
                check("redir_full flushed", 32'(instr_valid), 32'd0);
            if (imem.imem_req) begin
                found = 1'b1;
                check("redir_full addr", imem.imem_addr, 32'h0000_0200);
                break;
            end
        end
        check("redir_full request seen", 32'(found), 32'd1);

        @(negedge clk);
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
